// File: rtl/sipo_pkg.sv
// Shared constants and sizing helpers for the serial-in/parallel-out collector.
// Optional feature macro: SIPO_PARITY_EN (adds a trailing even-parity bit per frame).
package sipo_pkg;

  localparam int unsigned WIDTH_DEF = 4;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  function automatic int unsigned frame_len(input int unsigned w);
`ifdef SIPO_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

  localparam int unsigned CNT_W     = cnt_width(WIDTH_DEF);
  localparam int unsigned FRAME_LEN = frame_len(WIDTH_DEF);

endpackage

// File: rtl/sipo_if.sv
// Serial input and parallel word handshake bundle for sipo_collector.
// Optional feature macro: SIPO_PARITY_EN (adds parity_err).
interface sipo_if
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);
  logic             shift_en;
  logic             Din;
  logic             clear;
  logic             out_ready;
  logic [WIDTH-1:0] Dout;
  logic             out_valid;
  logic             overrun;
`ifdef SIPO_PARITY_EN
  logic             parity_err;

  modport master (output shift_en, Din, clear, out_ready,
                  input  Dout, out_valid, overrun, parity_err);
  modport slave  (input  shift_en, Din, clear, out_ready,
                  output Dout, out_valid, overrun, parity_err);
`else
  modport master (output shift_en, Din, clear, out_ready,
                  input  Dout, out_valid, overrun);
  modport slave  (input  shift_en, Din, clear, out_ready,
                  output Dout, out_valid, overrun);
`endif
endinterface

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit MSB-first shift register with enable, synchronous clear and async reset.
module sipo_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= {q[WIDTH-2:0], din};
  end

endmodule

// File: rtl/sipo_collector.sv
// Assembles MSB-first serial bits into WIDTH-bit words with valid/ready output and sticky overrun.
// Optional feature macro: SIPO_PARITY_EN (even-parity bit after each word, parity_err pulse).
module sipo_collector
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic  Clk,
  input  logic  reset,
  sipo_if.slave bus
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam int unsigned   FLEN = frame_len(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             ovr_q;
  logic             sr_en;
  logic             ok;
  logic             done;

`ifdef SIPO_PARITY_EN
  logic perr_q;

  // Parity slot: register holds the finished word, so the parity bit is only checked, never shifted.
  assign sr_en = bus.shift_en && (cnt != LAST);
  assign word  = sr;
  assign ok    = ~(^sr ^ bus.Din);
  assign bus.parity_err = perr_q;
`else
  logic sr_msb_unused;

  assign sr_en = bus.shift_en;
  assign word  = {sr[WIDTH-2:0], bus.Din};
  assign ok    = 1'b1;
  assign sr_msb_unused = sr[WIDTH-1];
`endif

  assign done = bus.shift_en && !bus.clear && (cnt == LAST);

  sipo_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk   (Clk),
    .reset (reset),
    .en    (sr_en),
    .clr   (bus.clear),
    .din   (bus.Din),
    .q     (sr)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      if (bus.clear) begin
        cnt   <= '0;
        ovr_q <= 1'b0;
      end else if (bus.shift_en) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end

      if (valid_q && bus.out_ready)
        valid_q <= 1'b0;

      if (done && ok) begin
        if (!valid_q || bus.out_ready) begin
          dout_q  <= word;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
`ifdef SIPO_PARITY_EN
      perr_q <= done && !ok;
`endif
    end
  end

  assign bus.Dout      = dout_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_collector.sv
// Directed self-checking bench for sipo_collector (WIDTH=4), default and SIPO_PARITY_EN builds.
module tb_sipo_collector;

  logic Clk;
  logic reset;
  int   passed;
  int   total;

  sipo_if #(.WIDTH(4)) bus ();

  sipo_collector #(.WIDTH(4)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.shift_en = 1'b1;
    bus.Din      = b;
    @(posedge Clk);
    #1;
    bus.shift_en = 1'b0;
    bus.Din      = 1'b0;
  endtask

  // Frame = 4 data bits MSB first, plus even parity when enabled; out_ready applied on the final edge only.
  task automatic send_word(input logic [3:0] w, input logic rdy_last, input int gap);
    logic [4:0] fr;
    int         nb;
`ifdef SIPO_PARITY_EN
    fr = {w, ^w};
    nb = 5;
`else
    fr = {1'b0, w};
    nb = 4;
`endif
    for (int i = nb - 1; i >= 0; i--) begin
      if (i == 0) bus.out_ready = rdy_last;
      send_bit(fr[i]);
      if (i != 0 && gap > 0) idle(gap);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset         = 1'b1;
    bus.shift_en  = 1'b1;
    bus.Din       = 1'b1;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;

    idle(3);
    chk("rst_dout",  bus.Dout,      4'h0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_ovr",   bus.overrun,   1'b0);
    reset        = 1'b0;
    bus.shift_en = 1'b0;
    bus.Din      = 1'b0;
    idle(2);
    chk("idle_valid", bus.out_valid, 1'b0);

    send_word(4'b1011, 1'b0, 0);
    chk("w1_dout",  bus.Dout,      4'b1011);
    chk("w1_valid", bus.out_valid, 1'b1);
    idle(10);
    chk("w1_hold_dout",  bus.Dout,      4'b1011);
    chk("w1_hold_valid", bus.out_valid, 1'b1);

    send_word(4'b0110, 1'b0, 0);
    chk("ovr_set",   bus.overrun,   1'b1);
    chk("ovr_dout",  bus.Dout,      4'b1011);
    chk("ovr_valid", bus.out_valid, 1'b1);
    drain();
    chk("xfer_valid", bus.out_valid, 1'b0);
    chk("xfer_ovr",   bus.overrun,   1'b1);
    chk("xfer_dout",  bus.Dout,      4'b1011);
    bus.clear = 1'b1;
    idle(1);
    bus.clear = 1'b0;
    chk("clr_ovr",   bus.overrun,   1'b0);
    chk("clr_dout",  bus.Dout,      4'b1011);
    chk("clr_valid", bus.out_valid, 1'b0);

    send_word(4'b1100, 1'b0, 0);
    chk("w2_dout", bus.Dout, 4'b1100);
    send_word(4'b0011, 1'b1, 0);
    chk("same_edge_dout",  bus.Dout,      4'b0011);
    chk("same_edge_valid", bus.out_valid, 1'b1);
    chk("same_edge_ovr",   bus.overrun,   1'b0);
    drain();
    chk("drain_valid", bus.out_valid, 1'b0);

    send_word(4'b1010, 1'b1, 0);
    chk("b2b_a_dout", bus.Dout, 4'b1010);
    send_word(4'b0110, 1'b1, 0);
    chk("b2b_b_dout",  bus.Dout,      4'b0110);
    chk("b2b_b_valid", bus.out_valid, 1'b1);
    chk("b2b_b_ovr",   bus.overrun,   1'b0);
    drain();

    send_word(4'b1001, 1'b0, 3);
    chk("gap_dout",  bus.Dout,      4'b1001);
    chk("gap_valid", bus.out_valid, 1'b1);
    drain();

    send_bit(1'b1);
    send_bit(1'b1);
    bus.clear    = 1'b1;
    bus.shift_en = 1'b1;
    bus.Din      = 1'b1;
    idle(1);
    bus.clear    = 1'b0;
    bus.shift_en = 1'b0;
    bus.Din      = 1'b0;
    chk("clr_mid_valid", bus.out_valid, 1'b0);
    send_word(4'b0101, 1'b0, 0);
    chk("clr_word_dout",  bus.Dout,      4'b0101);
    chk("clr_word_valid", bus.out_valid, 1'b1);

    send_word(4'b1110, 1'b0, 0);
    chk("pre_rst_ovr", bus.overrun, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_dout",  bus.Dout,      4'h0);
    chk("async_rst_valid", bus.out_valid, 1'b0);
    chk("async_rst_ovr",   bus.overrun,   1'b0);
    @(posedge Clk);
    #1;
    reset = 1'b0;
    send_word(4'b0111, 1'b0, 0);
    chk("post_rst_dout",  bus.Dout,      4'b0111);
    chk("post_rst_valid", bus.out_valid, 1'b1);
    drain();

`ifdef SIPO_PARITY_EN
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("par_ok_dout",  bus.Dout,       4'b1011);
    chk("par_ok_valid", bus.out_valid,  1'b1);
    chk("par_ok_err",   bus.parity_err, 1'b0);
    drain();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("par_bad_err",   bus.parity_err, 1'b1);
    chk("par_bad_valid", bus.out_valid,  1'b0);
    chk("par_bad_dout",  bus.Dout,       4'b1011);
    chk("par_bad_ovr",   bus.overrun,    1'b0);
    idle(1);
    chk("par_err_pulse", bus.parity_err, 1'b0);
    send_word(4'b0011, 1'b0, 0);
    chk("par_next_dout", bus.Dout, 4'b0011);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sipo_collector.md
# sipo_collector

Serial-in, parallel-out collector that sits directly downstream of the 4-bit parallel-to-serial shifter. It samples one serial bit per enabled clock, MSB first, and assembles a WIDTH-bit word. Each completed word is presented on a registered parallel output with a valid/ready handshake. Words that arrive while the output is still occupied are reported with a sticky overrun flag.

## Interface
Parameters:
- WIDTH, 4, bits per word (≥2)

Ports:
- Clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- shift_en  input  1  Din carries a valid bit this cycle
- Din  input  1  serial data, MSB of word first
- clear  input  1  synchronous abort of the partially received word
- out_ready  input  1  consumer accepts Dout this cycle
- Dout  output  WIDTH  assembled word; registered
- out_valid  output  1  Dout holds an unconsumed word
- overrun  output  1  sticky: a completed word was dropped
- parity_err  output  1  present only with SIPO_PARITY_EN; one-cycle pulse

## Operation
- Reset (async, active-high) sets:
  - shift register = 0, bit counter = 0
  - Dout = 0, out_valid = 0, overrun = 0, parity_err = 0
- Reset asserted mid-word discards the partial word and any pending output.
- Shift path: each edge with shift_en=1, shift register <= {sr[WIDTH-2:0], Din} and counter increments.
- Gaps in shift_en hold all state; no timeout.
- Completion: an edge with shift_en=1 and counter = WIDTH-1 completes the word. Counter wraps to 0.
- On completion, the word is {sr[WIDTH-2:0], Din}:
  - out_valid=0, or out_valid=1 and out_ready=1 on the same edge: load Dout, out_valid=1.
  - out_valid=1 and out_ready=0: drop the word, set overrun=1. Dout is unchanged.
- Handshake:
  - A transfer occurs on an edge with out_valid=1 and out_ready=1.
  - out_valid falls after a transfer unless a new word loads on the same edge.
  - Dout is stable while out_valid=1.
- clear:
  - Zeroes the counter and shift register, and clears overrun.
  - Does not affect Dout or out_valid.
  - When clear and shift_en are both high, clear wins and the bit is discarded.

## Timing
- Last bit sampled at edge N: Dout and out_valid are valid immediately after edge N (zero extra cycles).
- Minimum word period is WIDTH cycles. Back-to-back words are sustained with out_ready held high.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro SIPO_PARITY_EN.
- Defined:
  - Frame is WIDTH data bits followed by one even-parity bit (total count of 1s in the frame is even).
  - Counter runs 0..WIDTH.
  - The parity bit is not shifted into the data.
  - Mismatch: word discarded, out_valid unchanged, parity_err pulses high for one cycle after the parity edge, overrun unaffected.
  - Match: normal completion rules apply on the parity edge.
- Undefined: frame is WIDTH bits, the parity_err port is absent, and behaviour is as described above.

## Structure
- Shared package sipo_pkg holds:
  - default WIDTH constant
  - counter width, $clog2(WIDTH+1) so the parity slot fits
  - frame length constant, WIDTH or WIDTH+1 depending on macro
- One sub-module, sipo_shift_reg: WIDTH-bit shift register with enable and synchronous clear, async reset.
- The counter, output register and flags live in sipo_collector.

## Test plan
- Reset and shift_en stay high, then deassert → Dout=0, out_valid=0, overrun=0, and the counter stays 0 until the first enabled bit.
- WIDTH=4, bits 1,0,1,1 on consecutive enables with out_ready=0 → after the 4th edge Dout=4'b1011, out_valid=1, held over 10 further cycles.
- Pending 1011, shift 0,1,1,0 with out_ready=0 → overrun=1, Dout stays 1011. Then out_ready=1 for one cycle → out_valid=0, overrun stays 1 until clear.
- Pending word, out_ready=1 on the same edge as the last bit of 0,0,1,1 → Dout=4'b0011, out_valid stays 1, no overrun.
- Shift 1,1, then clear with shift_en=1, then 0,1,0,1 → Dout=4'b0101. Reset asserted after 2 bits → all outputs 0 and the next 4 bits form a fresh word.
- SIPO_PARITY_EN: frame 1,0,1,1 then parity 1 → Dout=1011, valid. Frame 1,0,1,1 then parity 0 → parity_err one-cycle pulse, out_valid stays 0.
